config_readback: RTL and testbench
==================================

// Module: config_readback
// PURPOSE
//  - CPU-facing readback engine for the config latch array. Selects one latch row (or scans all
//    rows), captures the WIDTH-bit row into a shadow register, and returns it as 32-bit words.
//  - Scan mode also builds a 32-bit rotate-XOR signature over every row.
//  - Sits beside the config write path on the same peripheral bus. Shares DEPTH, WIDTH and the
//    DEPTH-1..0 row order with the config loader.
// PARAMETERS
//  DEPTH     8    number of latch rows (2..32)
//  WIDTH     64   bits per row (33..64); upper word = row[WIDTH-1:32], zero-extended
//  IDX_BITS  3    derived: DEPTH>16 ? 5 : DEPTH>8 ? 4 : 3 (localparam)
// PORTS
//  clk        in   1         system clock
//  rst        in   1         synchronous reset, active-high
//  write_req  in   1         one-cycle bus write strobe
//  read_req   in   1         one-cycle bus read strobe
//  address    in   4         register offset: 0x0 LO, 0x4 HI, 0x8 CMD/STATUS, 0xC SIG
//  data_in    in   32        write data
//  data_out   out  32        registered read data
//  data_ready out  1         one-cycle pulse, data_out valid
//  row_sel    out  IDX_BITS  latch row select to the array mux
//  row_rd_en  out  1         row mux enable; row_data is valid the cycle after assertion
//  row_data   in   WIDTH     selected row contents
// BEHAVIOUR
//  - Interface decided: one clock, clk. Reset rst is synchronous and active-high.
//  - Reset (also mid-operation): FSM to IDLE; shadow, sig, err, done, data_out, data_ready,
//    row_sel, row_rd_en all cleared. Any pending read is dropped.
//  - CMD write (write_req, addr 0x8), accepted only in IDLE:
//    - data_in[4:0] = row, data_in[8] = scan.
//    - Single-row command with row >= DEPTH: rejected, err<=1, FSM stays IDLE.
//    - Accepted command clears err and done.
//    - Scan starts at row DEPTH-1 and clears sig; data_in[4:0] is ignored.
//    - Writes while busy, and writes to other addresses, are ignored.
//  - FSM states and transitions:
//    - IDLE -> SELECT on an accepted command.
//    - SELECT: row_rd_en=1, row_sel=cur_row.
//    - SAMPLE: shadow<=row_data. In scan, sig <= {sig[30:0],sig[31]} ^ row[31:0] ^ hi_ext.
//      Then: scan and cur_row!=0 -> cur_row-1, go to SELECT; otherwise go to DONE.
//    - DONE: done<=1, then return to IDLE.
//    - busy = (state != IDLE).
//  - Latency, write strobe at cycle 0:
//    - Single row: SELECT c1, SAMPLE c2, DONE c3, busy low at c4.
//    - Scan: 2*DEPTH+1 busy cycles.
//  - Reads:
//    - read_req at cycle N -> data_out/data_ready at N+1.
//    - LO = shadow[31:0]; HI = zero-extended shadow[WIDTH-1:32]; SIG = sig.
//    - STATUS = {19'b0, cur_row[4:0] at [12:8], 5'b0, done[2], err[1], busy[0]}.
//    - Read of LO/HI/SIG while busy is stalled. The request is latched, data_ready stays low,
//      and the read is serviced the cycle after busy falls. A STATUS read never stalls.
//    - Only one pending read. A new read_req while one is pending is ignored.
//    - Read of an undefined address returns 0 with the normal 1-cycle ready.
//  - Simultaneous CMD write and read in IDLE: the write starts the FSM. A LO/HI/SIG read in the
//    same cycle returns the pre-command shadow/sig (sampled before the FSM starts); it is not
//    stalled.
//  - row_sel holds its last value in IDLE. row_rd_en is asserted only in SELECT.
// STRUCTURE
//  - config_pkg:
//    - register offset constants (0x0/0x4/0x8/0xC)
//    - state enum: IDLE/SELECT/SAMPLE/DONE
//    - idx_bits(DEPTH) function shared with the loader
//    - status bit positions
//  - Sub-module readback_signature: clear, step, 32-bit rotate-XOR accumulator, 1-cycle update.
//  - Top level: FSM, shadow register, read mux, pending-read logic.
// TESTING
//  - Row 5 = 64'h1234_5678_9ABC_DEF0, CMD 0x5, poll STATUS until busy=0:
//    LO -> 0x9ABC_DEF0, HI -> 0x1234_5678, done=1.
//  - Only row 7 = 64'h0000_0001_0000_0002, others 0, CMD 0x100, wait:
//    SIG -> 0x0000_0180, LO/HI = row 0 = 0. row_sel sequence 7..0, 17 busy cycles.
//  - CMD 0x5, then read LO at c1: data_ready held low through busy, pulses at c5 with
//    0x9ABC_DEF0. A STATUS read at c2 returns busy=1 at c3.
//  - CMD 0x9 with DEPTH=8: err=1, busy never set, shadow unchanged. Next CMD 0x2 clears err.
//  - rst asserted mid-scan (row 4): next cycle every output is 0. A SIG read returns 0. A new
//    scan restarts at row 7.
//  - CMD write during a scan: ignored, row_sel sequence unaffected. WIDTH=40 build: HI upper
//    24 bits read 0.

Source files
------------

// File: rtl/config_readback_pkg.sv
// Shared constants, state encoding and sizing helper for the
// config latch array readback engine and its loader.
package config_readback_pkg;

  localparam logic [3:0] ADDR_LO  = 4'h0;
  localparam logic [3:0] ADDR_HI  = 4'h4;
  localparam logic [3:0] ADDR_CMD = 4'h8;
  localparam logic [3:0] ADDR_SIG = 4'hC;

  localparam int CMD_SCAN_BIT = 8;

  localparam int ST_BUSY    = 0;
  localparam int ST_ERR     = 1;
  localparam int ST_DONE    = 2;
  localparam int ST_ROW_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SAMPLE,
    DONE
  } rb_state_e;

  function automatic int idx_bits(input int depth);
    return (depth > 16) ? 5 : (depth > 8) ? 4 : 3;
  endfunction

endpackage

// File: rtl/config_readback_if.sv
// Peripheral bus bundle: write/read strobes, address, data,
// registered read data and its one-cycle ready pulse.
interface config_readback_if;

  logic        write_req;
  logic        read_req;
  logic [3:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output write_req, read_req, address, data_in,
    input  data_out, data_ready
  );

  modport slave (
    input  write_req, read_req, address, data_in,
    output data_out, data_ready
  );

endinterface

// File: rtl/config_readback_signature.sv
// Rotate-XOR signature: clear, step, 1-cycle update.
// Ports: clk, rst, clear, step, row (WIDTH), sig (32).
module config_readback_signature #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [WIDTH-1:0] row,
  output logic [31:0]      sig
);

  logic [31:0] hi_ext;

  assign hi_ext = 32'(row[WIDTH-1:32]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (step) begin
      sig <= {sig[30:0], sig[31]}
           ^ row[31:0] ^ hi_ext;
    end
  end

endmodule

// File: rtl/config_readback.sv
// Config latch readback: row/scan capture, shadow, signature.
// Ports: clk, rst, bus (slave), row_sel, row_rd_en, row_data.
module config_readback
  import config_readback_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int WIDTH    = 64,
  localparam int IDX_BITS = idx_bits(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  config_readback_if.slave    bus,
  output logic [IDX_BITS-1:0] row_sel,
  output logic                row_rd_en,
  input  logic [WIDTH-1:0]    row_data
);

  rb_state_e state_q, state_d;

  logic [IDX_BITS-1:0] cur_row;
  logic                scan_q;
  logic                err_q;
  logic                done_q;
  logic [WIDTH-1:0]    shadow;
  logic [31:0]         sig;

  logic busy;
  logic cmd_wr;
  logic cmd_scan;
  logic cmd_bad;
  logic cmd_ok;
  logic more_rows;

  logic        pend_q;
  logic [3:0]  pend_addr;
  logic        serve_pend;
  logic        rd_stall;
  logic [3:0]  rd_addr;
  logic [31:0] rd_word;
  logic [31:0] status;

  logic unused_data_in;

  assign unused_data_in = ^{bus.data_in[31:9],
                            bus.data_in[7:5]};

  assign busy     = (state_q != IDLE);
  assign cmd_wr   = bus.write_req && !busy &&
                    (bus.address == ADDR_CMD);
  assign cmd_scan = bus.data_in[CMD_SCAN_BIT];
  assign cmd_bad  = !cmd_scan &&
                    ({27'b0, bus.data_in[4:0]} >= DEPTH);
  assign cmd_ok   = cmd_wr && !cmd_bad;
  assign more_rows = scan_q && (cur_row != '0);
  assign row_sel  = cur_row;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    row_rd_en = 1'b0;
    unique case (state_q)
      IDLE:   if (cmd_ok) state_d = SELECT;
      SELECT: begin
        row_rd_en = 1'b1;
        state_d   = SAMPLE;
      end
      SAMPLE: state_d = more_rows ? SELECT : DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_row <= '0;
      scan_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      shadow  <= '0;
    end else begin
      if (cmd_wr) begin
        if (cmd_bad) begin
          err_q <= 1'b1;
        end else begin
          err_q   <= 1'b0;
          done_q  <= 1'b0;
          scan_q  <= cmd_scan;
          cur_row <= cmd_scan ? IDX_BITS'(DEPTH - 1)
                              : bus.data_in[IDX_BITS-1:0];
        end
      end
      if (state_q == SAMPLE) begin
        shadow <= row_data;
        if (more_rows) cur_row <= cur_row - IDX_BITS'(1);
      end
      if (state_q == DONE) done_q <= 1'b1;
    end
  end

  config_readback_signature #(
    .WIDTH (WIDTH)
  ) u_sig (
    .clk   (clk),
    .rst   (rst),
    .clear (cmd_ok && cmd_scan),
    .step  ((state_q == SAMPLE) && scan_q),
    .row   (row_data),
    .sig   (sig)
  );

  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_ERR]  = err_q;
    status[ST_DONE] = done_q;
    status[ST_ROW_LSB +: 5] = 5'(cur_row);
  end

  // A parked read is answered on the first idle cycle;
  // it takes the mux ahead of any new request.
  assign serve_pend = pend_q && !busy;
  assign rd_addr    = serve_pend ? pend_addr
                                 : bus.address;
  assign rd_stall   = (bus.address == ADDR_LO) ||
                      (bus.address == ADDR_HI) ||
                      (bus.address == ADDR_SIG);

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      rd_addr == ADDR_LO:  rd_word = shadow[31:0];
      rd_addr == ADDR_HI:  rd_word = 32'(shadow[WIDTH-1:32]);
      rd_addr == ADDR_CMD: rd_word = status;
      rd_addr == ADDR_SIG: rd_word = sig;
      default:             rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q         <= 1'b0;
      pend_addr      <= '0;
      bus.data_out   <= '0;
      bus.data_ready <= 1'b0;
    end else begin
      bus.data_ready <= 1'b0;
      if (serve_pend) begin
        bus.data_out   <= rd_word;
        bus.data_ready <= 1'b1;
        pend_q         <= 1'b0;
      end else if (bus.read_req) begin
        if (busy && rd_stall) begin
          if (!pend_q) begin
            pend_q    <= 1'b1;
            pend_addr <= bus.address;
          end
        end else begin
          bus.data_out   <= rd_word;
          bus.data_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_config_readback.sv
// Self-checking bench for config_readback: scoreboard of
// expected read data plus inline latency/handshake checks.
module tb_config_readback;

  typedef struct {
    logic [31:0] data;
    logic        chk;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  config_readback_if bus ();
  config_readback_if bus2 ();

  logic [2:0]  row_sel;
  logic        row_rd_en;
  logic [63:0] row_data = '0;
  logic [63:0] rows [8];

  logic [2:0]  row_sel2;
  logic        row_rd_en2;
  logic [39:0] row_data2 = '0;
  logic [39:0] rows2 [8];

  exp_t       exp_q[$];
  logic [2:0] sel_log[$];
  int passed = 0;
  int total  = 0;

  config_readback #(.DEPTH(8), .WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .row_sel   (row_sel),
    .row_rd_en (row_rd_en),
    .row_data  (row_data)
  );

  config_readback #(.DEPTH(4), .WIDTH(40)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .row_sel   (row_sel2),
    .row_rd_en (row_rd_en2),
    .row_data  (row_data2)
  );

  // latch array models: data valid the cycle after enable
  always @(posedge clk) begin
    if (row_rd_en) row_data <= rows[row_sel];
    if (row_rd_en2) row_data2 <= rows2[row_sel2];
    if (row_rd_en && !rst) sel_log.push_back(row_sel);
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.data_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL spurious_ready got=%h exp=none",
                 bus.data_out);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) begin
          total++;
          if (bus.data_out !== e.data)
            $display("FAIL %s got=%h exp=%h",
                     e.name, bus.data_out, e.data);
          else passed++;
        end
      end
    end
  end

  function automatic logic [31:0] sig_model();
    logic [31:0] s = '0;
    for (int r = 7; r >= 0; r--)
      s = {s[30:0], s[31]} ^ rows[r][31:0] ^ rows[r][63:32];
    return s;
  endfunction

  task automatic rd(input logic [3:0] a,
                    input logic [31:0] e,
                    input string nm);
    bus.read_req = 1'b1;
    bus.address  = a;
    exp_q.push_back('{data: e, chk: 1'b1, name: nm});
    @(negedge clk);
    bus.read_req = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d);
    bus.write_req = 1'b1;
    bus.address   = a;
    bus.data_in   = d;
    @(negedge clk);
    bus.write_req = 1'b0;
  endtask

  // polls STATUS every cycle; nbusy = busy cycles seen
  task automatic wait_idle(output int nbusy);
    bit fin = 0;
    nbusy = 0;
    bus.read_req = 1'b1;
    bus.address  = 4'h8;
    exp_q.push_back('{data: '0, chk: 1'b0, name: "poll"});
    for (int k = 0; k < 100 && !fin; k++) begin
      @(negedge clk);
      if (bus.data_out[0]) begin
        nbusy++;
        exp_q.push_back('{data: '0, chk: 1'b0,
                          name: "poll"});
      end else begin
        bus.read_req = 1'b0;
        fin = 1;
      end
    end
    if (!fin) begin
      bus.read_req = 1'b0;
      total++;
      $display("FAIL wait_idle timeout busy=%0d", nbusy);
    end
  endtask

  task automatic check_sel_log(input string nm);
    bit ok = (sel_log.size() == 8);
    for (int i = 0; i < sel_log.size() && ok; i++)
      if (sel_log[i] !== 3'(7 - i)) ok = 0;
    total++;
    if (!ok) $display("FAIL %s got=%p exp=7..0",
                      nm, sel_log);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus.data_ready, bus.data_out, row_rd_en,
         row_sel} !== '0)
      $display("FAIL reset_outputs got=%b/%h/%b/%h exp=0",
               bus.data_ready, bus.data_out,
               row_rd_en, row_sel);
    else passed++;
    rd(4'h8, 32'h0, "reset_status");
    rd(4'h0, 32'h0, "reset_lo");
    rd(4'hC, 32'h0, "reset_sig");
  endtask

  task automatic test_single_row();
    int n;
    rows[5] = 64'h1234_5678_9ABC_DEF0;
    wr(4'h8, 32'h5);
    total++;
    if (row_rd_en !== 1'b1 || row_sel !== 3'd5)
      $display("FAIL single_select got=%b/%0d exp=1/5",
               row_rd_en, row_sel);
    else passed++;
    wait_idle(n);
    total++;
    if (n != 3) $display("FAIL single_busy got=%0d exp=3", n);
    else passed++;
    rd(4'h0, 32'h9ABC_DEF0, "single_lo");
    rd(4'h4, 32'h1234_5678, "single_hi");
    rd(4'h8, 32'h0000_0504, "single_status");
    rd(4'h6, 32'h0, "undef_addr");
  endtask

  task automatic test_error();
    int n;
    wr(4'h8, 32'h9);
    total++;
    if (row_rd_en !== 1'b0)
      $display("FAIL err_no_select got=%b exp=0", row_rd_en);
    else passed++;
    rd(4'h8, 32'h0000_0506, "err_status");
    rd(4'h0, 32'h9ABC_DEF0, "err_shadow_kept");
    rows[2] = 64'hCAFE_0000_0000_BEEF;
    wr(4'h8, 32'h2);
    wait_idle(n);
    total++;
    if (n != 3) $display("FAIL err_next_busy got=%0d exp=3", n);
    else passed++;
    rd(4'h8, 32'h0000_0204, "err_cleared_status");
    rd(4'h4, 32'hCAFE_0000, "row2_hi");
  endtask

  task automatic test_stall();
    rows[5] = 64'h1234_5678_9ABC_DEF0;
    wr(4'h8, 32'h5);
    bus.read_req = 1'b1;
    bus.address  = 4'h0;
    @(negedge clk);
    total++;
    if (bus.data_ready !== 1'b0)
      $display("FAIL stall_c2_ready got=%b exp=0",
               bus.data_ready);
    else passed++;
    bus.address = 4'h8;
    exp_q.push_back('{data: 32'h0000_0501, chk: 1'b1,
                      name: "stall_status"});
    exp_q.push_back('{data: 32'h9ABC_DEF0, chk: 1'b1,
                      name: "stall_lo"});
    @(negedge clk);
    bus.read_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.data_ready !== 1'b0)
      $display("FAIL stall_c4_ready got=%b exp=0",
               bus.data_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.data_ready !== 1'b1)
      $display("FAIL stall_c5_ready got=%b exp=1",
               bus.data_ready);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_scan();
    int n;
    foreach (rows[i]) rows[i] = '0;
    rows[7] = 64'h0000_0001_0000_0002;
    sel_log.delete();
    bus.write_req = 1'b1;
    bus.read_req  = 1'b1;
    bus.address   = 4'h8;
    bus.data_in   = 32'h100;
    exp_q.push_back('{data: 32'h0000_0504, chk: 1'b1,
                      name: "cmd_and_status"});
    @(negedge clk);
    bus.write_req = 1'b0;
    bus.read_req  = 1'b0;
    wait_idle(n);
    total++;
    if (n != 17) $display("FAIL scan_busy got=%0d exp=17", n);
    else passed++;
    check_sel_log("scan_rows");
    rd(4'hC, 32'h0000_0180, "scan_sig");
    rd(4'h0, 32'h0, "scan_lo");
    rd(4'h4, 32'h0, "scan_hi");
    rd(4'h8, 32'h0000_0004, "scan_status");
  endtask

  task automatic test_back_to_back();
    int n;
    foreach (rows[i]) rows[i] = {$urandom, $urandom};
    sel_log.delete();
    wr(4'h8, 32'h100);
    @(negedge clk);
    wr(4'h8, 32'h3);
    wait_idle(n);
    total++;
    if (n != 15) $display("FAIL b2b_busy got=%0d exp=15", n);
    else passed++;
    check_sel_log("b2b_rows");
    rd(4'hC, sig_model(), "b2b_sig");
    rd(4'h0, rows[0][31:0], "b2b_lo");
    rd(4'h4, rows[0][63:32], "b2b_hi");
  endtask

  task automatic test_reset_mid();
    int n;
    bit hit = 0;
    wr(4'h8, 32'h100);
    for (int k = 0; k < 40 && !hit; k++) begin
      if (row_rd_en && row_sel == 3'd4) hit = 1;
      else @(negedge clk);
    end
    total++;
    if (!hit) $display("FAIL mid_row4 got=none exp=row4");
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.data_ready, bus.data_out, row_rd_en,
         row_sel} !== '0)
      $display("FAIL mid_reset_outputs got=%b/%h/%b/%h exp=0",
               bus.data_ready, bus.data_out,
               row_rd_en, row_sel);
    else passed++;
    rst = 1'b0;
    rd(4'hC, 32'h0, "mid_sig");
    rd(4'h8, 32'h0, "mid_status");
    sel_log.delete();
    wr(4'h8, 32'h100);
    total++;
    if (row_rd_en !== 1'b1 || row_sel !== 3'd7)
      $display("FAIL mid_restart got=%b/%0d exp=1/7",
               row_rd_en, row_sel);
    else passed++;
    wait_idle(n);
    total++;
    if (n != 17) $display("FAIL mid_busy got=%0d exp=17", n);
    else passed++;
    check_sel_log("mid_rows");
  endtask

  task automatic test_width40();
    rows2[3] = 40'hAB_CDEF_0123;
    bus2.write_req = 1'b1;
    bus2.address   = 4'h8;
    bus2.data_in   = 32'h3;
    @(negedge clk);
    bus2.write_req = 1'b0;
    repeat (4) @(negedge clk);
    bus2.read_req = 1'b1;
    bus2.address  = 4'h4;
    @(negedge clk);
    bus2.address  = 4'h0;
    total++;
    if (bus2.data_ready !== 1'b1 ||
        bus2.data_out !== 32'h0000_00AB)
      $display("FAIL w40_hi got=%b/%h exp=1/000000ab",
               bus2.data_ready, bus2.data_out);
    else passed++;
    @(negedge clk);
    bus2.read_req = 1'b0;
    total++;
    if (bus2.data_out !== 32'hCDEF_0123)
      $display("FAIL w40_lo got=%h exp=cdef0123",
               bus2.data_out);
    else passed++;
    bus2.write_req = 1'b1;
    bus2.address   = 4'h8;
    bus2.data_in   = 32'h4;
    @(negedge clk);
    bus2.write_req = 1'b0;
    bus2.read_req  = 1'b1;
    @(negedge clk);
    bus2.read_req  = 1'b0;
    total++;
    if (bus2.data_out !== 32'h0000_0306)
      $display("FAIL w40_err_status got=%h exp=00000306",
               bus2.data_out);
    else passed++;
  endtask

  initial begin
    bus.write_req  = 1'b0;
    bus.read_req   = 1'b0;
    bus.address    = '0;
    bus.data_in    = '0;
    bus2.write_req = 1'b0;
    bus2.read_req  = 1'b0;
    bus2.address   = '0;
    bus2.data_in   = '0;
    foreach (rows[i]) rows[i] = '0;
    foreach (rows2[i]) rows2[i] = '0;
    test_reset();
    test_single_row();
    test_error();
    test_stall();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    test_width40();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0)
      $display("FAIL drain got=%0d exp=0 outstanding",
               exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
